key_seq: RTL
============

KEY_SEQ -- requirements
Module: key_seq

Interface
REQ-001 Ports SHALL be, in order:
- clk  in  1  system clock; one clock domain, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-002 Console inputs SHALL be:
- key_start, key_inst_stop, key_ex, key_ex_nxt, key_dep, key_dep_nxt  in  1 each  console keys, level while held.
- sw_mem_disable  in  1  suppress memory cycles.
- sw_power  in  1  power switch.
- datasw  in  [0:35]  data switches.
- mas  in  [18:35]  address switches.
REQ-003 Memory bus ports SHALL be:
- membus_rq  out  1  memory request.
- membus_wr  out  1  1 = write, 0 = read.
- membus_addr  out  [18:35]  address.
- membus_data_out  out  [0:35]  write data.
- membus_ack  in  1  memory acknowledge.
- membus_data_in  in  [0:35]  read data.
REQ-004 Light outputs SHALL be:
- ma  out  [18:35]  memory address register.
- mb  out  [0:35]  memory buffer.
- pc  out  [18:35]  program counter.
- run  out  1  run flip-flop.
- key_busy  out  1  sequence active.
- nxm  out  1  nonexistent-memory flag.
- power  out  1  mirrors sw_power combinationally.
REQ-005 Parameter TIMEOUT, default 255, SHALL set the number of cycles allowed for membus_ack.

Function
REQ-006 State machine SHALL use the states IDLE, KT1, KT2, MEM, REL.
REQ-007 In IDLE, a key whose value was 0 in the previous cycle and is 1 now (rising edge) SHALL be accepted only when sw_power=1; no key SHALL be accepted while key_busy=1.
REQ-008 Simultaneous key edges SHALL be resolved by fixed priority: inst_stop > start > dep_nxt > dep > ex_nxt > ex; only the winner SHALL act.
REQ-009 key_inst_stop SHALL clear run in the cycle after its edge, in any state, and SHALL go to REL.
REQ-010 key_start SHALL load pc <= mas, set run=1 and go to REL.
REQ-011 While run=1, the dep, dep_nxt, ex and ex_nxt keys SHALL be ignored.
REQ-012 IDLE -> KT1 on an accepted dep, dep_nxt, ex or ex_nxt key; the key code SHALL be latched.
REQ-013 KT1 SHALL load the address:
- dep and ex: ma <= mas.
- dep_nxt and ex_nxt: ma <= ma+1, modulo 2^18 (777777 wraps to 000000).
REQ-014 KT1 -> KT2 SHALL take exactly one cycle.
REQ-015 KT2 for dep and dep_nxt SHALL load mb <= datasw; for ex and ex_nxt mb is unchanged.
REQ-016 KT2 -> MEM when sw_mem_disable=0; KT2 -> REL when sw_mem_disable=1, with no bus cycle.
REQ-017 While in MEM, the bus outputs SHALL be:
- membus_rq = 1.
- membus_addr = ma.
- membus_wr = 1 for dep and dep_nxt, 0 for ex and ex_nxt.
- membus_data_out = mb.
REQ-018 MEM SHALL end on the first cycle with membus_ack=1:
- for reads, mb <= membus_data_in on that cycle;
- the state SHALL then go to REL;
- membus_rq SHALL be 0 in the following cycle.
REQ-019 If membus_ack is not seen within TIMEOUT cycles of entering MEM, nxm SHALL be set to 1, rq SHALL drop, mb SHALL be unchanged, and the state SHALL go to REL.
REQ-020 nxm SHALL be cleared when the next dep, dep_nxt, ex or ex_nxt key is accepted.
REQ-021 REL SHALL wait until all six keys read 0 for one cycle, then go to IDLE.
REQ-022 key_busy SHALL be 1 in every state except IDLE.
REQ-023 sw_power=0 SHALL force run=0, membus_rq=0 and a return to IDLE on the next cycle; register contents SHALL be retained.
REQ-024 membus_wr, membus_addr and membus_data_out SHALL be 0 whenever membus_rq=0.

Reset
REQ-025 On reset=1 at a clock edge, the following SHALL apply, overriding any operation in progress, including a pending MEM:
- state = IDLE;
- ma = 0, mb = 0, pc = 0;
- run = 0, nxm = 0, membus_rq = 0, key_busy = 0;
- timeout counter = 0;
- key edge history = 0, so a key still held after reset SHALL NOT act until it is released and pressed again.

Verification
REQ-026 Deposit: mas=001000, datasw=123456701234, pulse key_dep, ack after 3 cycles -> exactly one write at address 001000 with data 123456701234 and membus_wr=1; ma=001000; mb=123456701234; nxm=0.
REQ-027 Examine next with wrap: ma=777777, pulse key_ex_nxt, ack with data 000000000017 -> read at address 000000; mb=000000000017.
REQ-028 Timeout: pulse key_ex and never assert ack -> rq high for exactly 255 cycles, then nxm=1, state REL; the next key_ex with ack -> nxm=0.
REQ-029 Priority and run lockout: key_dep and key_start rise in the same cycle with mas=000100 -> pc=000100, run=1, no bus cycle; a later key_ex is ignored while run=1; key_inst_stop -> run=0.
REQ-030 Reset mid-cycle: assert reset during MEM -> next cycle rq=0, state IDLE, ma=0; a key still held after reset produces no bus cycle until it is released and pressed again.
REQ-031 Memory disable: sw_mem_disable=1, pulse key_dep with mas=000200 and datasw=5 -> ma=000200, mb=5, membus_rq never asserted.

Source files
------------

// File: rtl/key_seq.sv
// Console key sequencer: turns key presses into examine/deposit memory cycles and start/stop control.
// Latency: key edge -> address load 1 cycle, data load 2 cycles, bus request from the 3rd cycle.
// Backpressure: holds membus_rq until membus_ack or TIMEOUT cycles; further keys wait for full release.
module key_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_start,
  input  logic         key_inst_stop,
  input  logic         key_ex,
  input  logic         key_ex_nxt,
  input  logic         key_dep,
  input  logic         key_dep_nxt,
  input  logic         sw_mem_disable,
  input  logic         sw_power,
  input  logic [0:35]  datasw,
  input  logic [18:35] mas,
  output logic         membus_rq,
  output logic         membus_wr,
  output logic [18:35] membus_addr,
  output logic [0:35]  membus_data_out,
  input  logic         membus_ack,
  input  logic [0:35]  membus_data_in,
  output logic [18:35] ma,
  output logic [0:35]  mb,
  output logic [18:35] pc,
  output logic         run,
  output logic         key_busy,
  output logic         nxm,
  output logic         power
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, KT1, KT2, MEM, REL} state_t;

  typedef struct packed {
    logic dep;
    logic nxt;
  } key_cmd_t;

  state_t       state_q, state_d;
  key_cmd_t     cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]   key_arm_q;
  logic [5:0]   key_vec;
  logic [5:0]   key_rise;
  logic [18:35] ma_d;
  logic [0:35]  mb_d;
  logic [18:35] pc_d;
  logic         run_d;
  logic         nxm_d;

  assign key_vec  = {key_inst_stop, key_start, key_dep_nxt, key_dep, key_ex_nxt, key_ex};
  // A key arms only after being seen released, so keys held through reset stay inert.
  assign key_rise = key_vec & key_arm_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      key_arm_q <= '0;
      ma        <= '0;
      mb        <= '0;
      pc        <= '0;
      run       <= 1'b0;
      nxm       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      key_arm_q <= ~key_vec;
      ma        <= ma_d;
      mb        <= mb_d;
      pc        <= pc_d;
      run       <= run_d;
      nxm       <= nxm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    ma_d    = ma;
    mb_d    = mb;
    pc_d    = pc;
    run_d   = run;
    nxm_d   = nxm;

    if (!sw_power) begin
      state_d = IDLE;
      run_d   = 1'b0;
      cnt_d   = '0;
    end else if (key_rise[5]) begin
      run_d   = 1'b0;
      cnt_d   = '0;
      state_d = REL;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_rise[4]) begin
            pc_d    = mas;
            run_d   = 1'b1;
            state_d = REL;
          end else if (!run && (|key_rise[3:0])) begin
            nxm_d   = 1'b0;
            state_d = KT1;
            if (key_rise[3])      cmd_d = '{dep: 1'b1, nxt: 1'b1};
            else if (key_rise[2]) cmd_d = '{dep: 1'b1, nxt: 1'b0};
            else if (key_rise[1]) cmd_d = '{dep: 1'b0, nxt: 1'b1};
            else                  cmd_d = '{dep: 1'b0, nxt: 1'b0};
          end
        end
        KT1: begin
          ma_d    = cmd_q.nxt ? ma + 18'd1 : mas;
          state_d = KT2;
        end
        KT2: begin
          if (cmd_q.dep) mb_d = datasw;
          cnt_d   = '0;
          state_d = sw_mem_disable ? REL : MEM;
        end
        MEM: begin
          if (membus_ack) begin
            if (!cmd_q.dep) mb_d = membus_data_in;
            state_d = REL;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            nxm_d   = 1'b1;
            state_d = REL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REL: begin
          if (key_vec == 6'b0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign membus_rq       = (state_q == MEM) && sw_power;
  assign membus_wr       = membus_rq && cmd_q.dep;
  assign membus_addr     = membus_rq ? ma : '0;
  assign membus_data_out = membus_rq ? mb : '0;
  assign key_busy        = (state_q != IDLE);
  assign power           = sw_power;

endmodule
